// File: rtl/mask_index_encoder.sv
// Sequential mask-to-index encoder: one index per beat, ascending by default.
// Define ENC_MSB_FIRST_EN to emit indices in descending order instead.
module mask_index_encoder #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_mask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         in_empty
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t         state;
  logic [N-1:0]   pending;
  logic [N-1:0]   sel;
  logic [W-1:0]   idx;
  logic           single;

  // Priority pick over pending; the loop order decides which end wins.
  always_comb begin
    idx = '0;
    sel = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
`else
    for (int i = N - 1; i >= 0; i--) begin
`endif
      if (pending[i]) begin
        idx    = W'(i);
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
  end

  assign single = (pending != '0) &&
                  ((pending & (pending - N'(1))) == '0);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT);
  assign out_idx   = idx;
  assign out_last  = (state == EMIT) && single;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pending  <= '0;
      in_empty <= 1'b0;
    end else begin
      in_empty <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_mask != '0) begin
              pending <= in_mask;
              state   <= EMIT;
            end else begin
              in_empty <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (single) begin
              pending <= '0;
              state   <= IDLE;
            end else begin
              pending <= pending & ~sel;
            end
          end
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
        end
      endcase
    end
  end

endmodule
